// File: rtl/timer_pkg.sv
// Shared types and constants for the prescaled timer: FSM state encoding,
// digit-mode selectors and the prescaler width helper.
package timer_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_e;

    localparam int MODE_HEX = 0;
    localparam int MODE_BCD = 1;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] HEX_DIGIT_MAX = 4'hF;

    // Smallest width (at least 1) whose range covers 0..prescale-1.
    function automatic int prescale_width(input int prescale);
        int w;
        w = 1;
        while ((1 << w) < prescale) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One count nibble: adds or subtracts carry_i, producing the next digit and
// a carry (up) or borrow (down) into the next more significant nibble.
module bcd_digit_counter
    import timer_pkg::*;
#(
    parameter int BCD = MODE_HEX
) (
    input  logic [3:0] digit_i,
    input  logic       up_i,
    input  logic       carry_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    localparam logic [3:0] DIGIT_MAX = (BCD == MODE_BCD) ? BCD_DIGIT_MAX : HEX_DIGIT_MAX;

    // Next digit value and outgoing carry/borrow.
    always_comb begin
        digit_o = digit_i;
        carry_o = 1'b0;
        if (!carry_i) begin
            digit_o = digit_i;
            carry_o = 1'b0;
        end else if (up_i) begin
            // >= rather than == so an out-of-range BCD nibble still rolls over.
            if (digit_i >= DIGIT_MAX) begin
                digit_o = 4'd0;
                carry_o = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
                carry_o = 1'b0;
            end
        end else begin
            if (digit_i == 4'd0) begin
                digit_o = DIGIT_MAX;
                carry_o = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
                carry_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/prescaled_timer.sv
// Prescaled up/down digit timer with STOP/RUN/DONE control.
// Define TIMER_LAP_EN to add the lap input that freezes disp while count runs.
module prescaled_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_HZ  = 1,
    parameter int DIGITS   = 4,
    parameter int BCD      = MODE_HEX,
    parameter int ONE_SHOT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  dir,
`ifdef TIMER_LAP_EN
    input  logic                  lap,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  tick,
    output logic                  tc,
    output logic                  running,
    output logic                  done
);

    localparam int            PRESCALE = CLK_HZ / TICK_HZ;
    localparam int            PW       = prescale_width(PRESCALE);
    localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
    localparam int            CW       = 4 * DIGITS;

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("prescaled_timer: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("prescaled_timer: DIGITS must be in 1..8");
    end

    timer_state_e  state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;
    logic          tc_q, tc_d;
    logic          running_q, done_q;
    logic [CW-1:0] step_val_s;
    logic [CW-1:0] load_sat_s;
    logic [DIGITS:0] carry_s;
    logic          wrap_s;

    // A carry out of the top digit means the step started at the terminal value.
    assign carry_s[0] = 1'b1;
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_counter #(.BCD(BCD)) u_digit (
            .digit_i (count_q[4*g +: 4]),
            .up_i    (dir),
            .carry_i (carry_s[g]),
            .digit_o (step_val_s[4*g +: 4]),
            .carry_o (carry_s[g+1])
        );
    end

    assign wrap_s = (state_q == RUN) && (presc_q == PS_LAST);

    // Load value with BCD nibbles above 9 saturated.
    always_comb begin
        load_sat_s = load_val;
        if (BCD == MODE_BCD) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (load_val[4*i +: 4] > BCD_DIGIT_MAX) begin
                    load_sat_s[4*i +: 4] = BCD_DIGIT_MAX;
                end else begin
                    load_sat_s[4*i +: 4] = load_val[4*i +: 4];
                end
            end
        end else begin
            load_sat_s = load_val;
        end
    end

    // Next-state: clear > load > step; prescaler only advances in RUN.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (clear) begin
            state_d = STOP;
            presc_d = '0;
            count_d = '0;
        end else if (load) begin
            count_d = load_sat_s;
            presc_d = '0;
            state_d = (state_q == DONE) ? STOP : state_q;
        end else begin
            case (state_q)
                STOP: begin
                    state_d = enable ? RUN : STOP;
                end
                RUN: begin
                    if (wrap_s) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        tc_d    = carry_s[DIGITS];
                        if (carry_s[DIGITS] && (ONE_SHOT != 0)) begin
                            count_d = count_q;
                            state_d = DONE;
                        end else begin
                            count_d = step_val_s;
                            state_d = enable ? RUN : STOP;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                        state_d = enable ? RUN : STOP;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = STOP;
                end
            endcase
        end
    end

    // State, prescaler, count and status flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= STOP;
            presc_q   <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            tc_q      <= tc_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

`ifdef TIMER_LAP_EN
    logic          lap_q;
    logic [CW-1:0] lap_cap_q, lap_cap_d;

    // Capture count on the rising edge of lap.
    always_comb begin
        if (clear) begin
            lap_cap_d = '0;
        end else if (lap && !lap_q) begin
            lap_cap_d = count_q;
        end else begin
            lap_cap_d = lap_cap_q;
        end
    end

    // Lap edge detector and captured value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q     <= 1'b0;
            lap_cap_q <= '0;
        end else begin
            lap_q     <= lap;
            lap_cap_q <= lap_cap_d;
        end
    end

    // In the rising cycle the capture equals count_q, so count_q is shown directly.
    assign disp = (lap && lap_q) ? lap_cap_q : count_q;
`else
    assign disp = count_q;
`endif

    assign count   = count_q;
    assign tick    = tick_q;
    assign tc      = tc_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: doc/prescaled_timer.md
Name: prescaled_timer

Overview:
- Generalised seconds-style timer. A prescaler divides clk down to a tick rate, and a DIGITS-nibble counter advances on each tick.
- Counter counts up or down, in either hex or BCD digit mode.
- Supports load, clear, pause, and a wrap vs one-shot terminal policy.
- Output nibbles feed the existing seven-segment decoders at board top level; the decoders are not part of this block.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1, count rate. PRESCALE = CLK_HZ/TICK_HZ, which must be >= 2 (elaboration error otherwise).
- DIGITS, 4, number of 4-bit count digits. Range 1..8.
- BCD, 0, digit mode. 0 = binary across all nibbles; 1 = each nibble counts 0..9 with carry/borrow.
- ONE_SHOT, 0, terminal policy. 0 = wrap; 1 = stop in DONE.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; returns block to reset state.
- enable  in  1  run request; level-sensitive.
- clear  in  1  synchronous clear.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  value written on load.
- dir  in  1  1 = count up, 0 = count down.
- count  out  4*DIGITS  current count, registered.
- disp  out  4*DIGITS  display value (see Optional Feature).
- tick  out  1  one-cycle pulse per count step.
- tc  out  1  one-cycle terminal-count pulse.
- running  out  1  state == RUN.
- done  out  1  state == DONE.

Behaviour:
- Reset values:
  - count = 0, prescaler = 0.
  - tick = 0, tc = 0, running = 0, done = 0.
  - state = STOP.
- States are STOP, RUN and DONE.
  - STOP -> RUN when enable = 1.
  - RUN -> STOP when enable = 0. Prescaler holds its value; resuming continues the same period, so no period is lost or doubled.
  - RUN -> DONE on a terminal step when ONE_SHOT = 1. enable is ignored in DONE.
  - DONE -> STOP on clear or load.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN.
  - At PRESCALE-1 it wraps to 0 and a step occurs.
  - Exactly PRESCALE cycles separate steps.
- Step timing: count updates and tick is high in the same cycle, which is the cycle after the prescaler wrap. Both are registered.
- Terminal value: MAX when counting up (all F in hex, all 9 in BCD); 0 when counting down.
- A step taken while count is at the terminal value:
  - tc pulses with that step.
  - ONE_SHOT = 0: count wraps (MAX->0 up, 0->MAX down).
  - ONE_SHOT = 1: count holds and the state moves to DONE.
  - tick also pulses on this step.
- BCD arithmetic:
  - Per-digit carry/borrow; 9+1 -> 0 with carry, 0-1 -> 9 with borrow.
  - Any load_val nibble > 9 is saturated to 9 on load.
- Priority: reset > clear > load > step.
  - clear: count = 0, prescaler = 0, state = STOP. No tick or tc that cycle.
  - load: count = load_val, prescaler = 0. DONE -> STOP, otherwise state is unchanged. No tick or tc that cycle.
- dir is sampled at each step; a mid-run change takes effect on the next step.
- running and done are registered and track the state.
- Asserting reset mid-period returns everything to reset values asynchronously. The first step after release needs a full PRESCALE in RUN.

Optional Feature:
- Macro: TIMER_LAP_EN.
- Defined:
  - Adds input port lap (1 bit).
  - On the lap 0->1 edge, disp captures the count value of that same cycle and holds it while lap = 1, while count keeps running.
  - When lap = 0, disp = count.
  - reset and clear also clear the captured value.
- Undefined: no lap port; disp is a direct copy of count.

Decomposition:
- Package timer_pkg:
  - state enum {STOP, RUN, DONE}.
  - Mode constants MODE_HEX / MODE_BCD.
  - BCD_DIGIT_MAX = 9.
  - Prescaler width function (ceil log2 of PRESCALE).
- Sub-module bcd_digit_counter:
  - One nibble with up/down, carry_in and carry_out/borrow_out, and a BCD parameter.
  - Instantiated DIGITS times in a generate loop and chained.
  - The top holds the FSM, prescaler and lap logic.

Test Plan:
- CLK_HZ=10, TICK_HZ=1, BCD=1, dir=1, enable raised after reset -> first tick exactly 10 cycles after enable sampled, count 0x0001; after 25 ticks count 0x0025.
- BCD=1, load 0x9999, run up -> next step count 0x0000, tc and tick both pulse for exactly 1 cycle.
- ONE_SHOT=1, load 0x0003, dir=0, enable=1 -> 0002, 0001, 0000. Next step: tc pulses, done=1, count holds 0000 for 50 cycles with enable high. Then clear -> STOP, then RUN on the following cycle.
- Drop enable when the prescaler reads 6, hold low 20 cycles, raise it -> next tick exactly 4 cycles later; count unchanged during the pause.
- clear and load asserted on the step cycle -> count 0, no tick, no tc. load alone on the step cycle -> count = load_val, no tick.
- BCD=0: load 0x0009, step up -> 0x000A. BCD=1: load 0x00AF -> count 0x0099. With TIMER_LAP_EN: raise lap at count 0x0012 -> disp holds 0x0012 while count reaches 0x0015; drop lap -> disp 0x0015.
